v74x148_seq_encoder: RTL and testbench

- Registered 4-to-2 priority encoder with active-low request lines; the inverse of the 2-to-4 active-low decoder.
- Collects active-low strobes (for example the Y0_L..Y3_L lines of decoder instances), synchronises them and encodes the highest-priority active line.
- Holds the code on a VALID/ACK handshake until consumed, then re-arms per line so one long request is reported only once.

---
 rtl/v74x_pkg.sv | 20 ++
 rtl/v74x_sync_bit.sv | 34 +++
 rtl/v74x148_seq_encoder.sv | 105 ++++++++++
 tb/tb_v74x148_seq_encoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/v74x_pkg.sv
// Shared constants and helpers for the 74x148-style sequential encoder.
package v74x_pkg;

    localparam int unsigned N_LINES = 4;
    localparam int unsigned CODE_W  = 2;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    // Index of the highest set bit; bit 3 has top priority.
    function automatic logic [CODE_W-1:0] prio4(input logic [N_LINES-1:0] v);
        logic [CODE_W-1:0] idx;
        if (v[3])      idx = 2'd3;
        else if (v[2]) idx = 2'd2;
        else if (v[1]) idx = 2'd1;
        else           idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/v74x_sync_bit.sv
// Single-bit multi-flop synchroniser; resets to 1 (inactive for active-low lines).
module v74x_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input one stage per clock.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops with synchronous reset to all ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/v74x148_seq_encoder.sv
// Registered active-low 4-to-2 priority encoder with VALID/ACK hold and per-line re-arm.
module v74x148_seq_encoder
    import v74x_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REARM       = 1
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       EI_L,
    input  logic [3:0] I_L,
    input  logic       ACK,
    output logic       B,
    output logic       A,
    output logic       VALID,
    output logic       GS_L,
    output logic       EO_L
);

    logic [N_LINES-1:0] sync_out;
    logic [N_LINES-1:0] req;
    logic [N_LINES-1:0] eligible;
    logic [N_LINES-1:0] arm_q, arm_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  cap_idx;
    logic               state_q, state_d;
    logic               valid_q, valid_d;
    logic               gs_q, gs_d;
    logic               eo_q, eo_d;
    logic               capture;

    // One synchroniser per request line.
    for (genvar g = 0; g < N_LINES; g++) begin : g_sync
        v74x_sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (CLK),
            .rst_ni(RESET_L),
            .d_i   (I_L[g]),
            .q_o   (sync_out[g])
        );
    end

    assign req = ~sync_out;

    // Eligibility, FSM next state, code capture and arm bookkeeping.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        gs_d    = gs_q;
        arm_d   = arm_q;

        eligible = (REARM != 0) ? (req & arm_q) : req;
        capture  = (state_q == ST_IDLE) && !EI_L && (eligible != '0);
        cap_idx  = prio4(eligible);

        if (state_q == ST_IDLE) begin
            if (capture) begin
                code_d  = cap_idx;
                valid_d = 1'b1;
                gs_d    = 1'b0;
                state_d = ST_HOLD;
                arm_d[cap_idx] = 1'b0;
            end
        end else begin
            if (ACK) begin
                valid_d = 1'b0;
                gs_d    = 1'b1;
                state_d = ST_IDLE;
            end
        end

        // A line seen high (inactive) re-arms; no conflict with the clear above.
        arm_d = arm_d | sync_out;

        eo_d = ~((state_d == ST_IDLE) && !EI_L && (eligible == '0));
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            gs_q    <= 1'b1;
            eo_q    <= 1'b1;
            arm_q   <= '1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            gs_q    <= gs_d;
            eo_q    <= eo_d;
            arm_q   <= arm_d;
        end
    end

    assign B     = code_q[1];
    assign A     = code_q[0];
    assign VALID = valid_q;
    assign GS_L  = gs_q;
    assign EO_L  = eo_q;

endmodule

// File: tb/tb_v74x148_seq_encoder.sv
// Bench for v74x148_seq_encoder: one REARM=1 and one REARM=0 instance on shared stimulus.
module tb_v74x148_seq_encoder;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       ei_l;
    logic [3:0] i_l;
    logic       ack;
    logic       b_w[2], a_w[2], valid_w[2], gs_w[2], eo_w[2];

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = REARM=1, index 1 = REARM=0.
    logic [3:0] hist [S];
    logic       m_hold [2];
    logic       m_valid[2];
    logic [1:0] m_code [2];
    logic       m_eo   [2];
    logic [3:0] m_arm  [2];

    always #5 clk = ~clk;

    v74x148_seq_encoder #(.SYNC_STAGES(S), .REARM(1)) dut0 (
        .CLK(clk), .RESET_L(rst_l), .EI_L(ei_l), .I_L(i_l), .ACK(ack),
        .B(b_w[0]), .A(a_w[0]), .VALID(valid_w[0]), .GS_L(gs_w[0]), .EO_L(eo_w[0])
    );

    v74x148_seq_encoder #(.SYNC_STAGES(S), .REARM(0)) dut1 (
        .CLK(clk), .RESET_L(rst_l), .EI_L(ei_l), .I_L(i_l), .ACK(ack),
        .B(b_w[1]), .A(a_w[1]), .VALID(valid_w[1]), .GS_L(gs_w[1]), .EO_L(eo_w[1])
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using current inputs, clock the DUTs, compare.
    task automatic tick();
        logic [3:0] synced, req, elig;
        int idx;
        synced = hist[S-1];
        req    = ~synced;
        for (int d = 0; d < 2; d++) begin
            if (!rst_l) begin
                m_hold[d] = 1'b0; m_valid[d] = 1'b0; m_code[d] = 2'd0;
                m_eo[d] = 1'b1; m_arm[d] = 4'hF;
            end else begin
                elig = (d == 0) ? (req & m_arm[d]) : req;
                if (!m_hold[d]) begin
                    if (!ei_l && elig != 4'd0) begin
                        idx = $clog2(int'(elig) + 1) - 1;
                        m_hold[d] = 1'b1; m_valid[d] = 1'b1; m_code[d] = 2'(idx);
                        if (d == 0) m_arm[d][idx] = 1'b0;
                    end
                end else if (ack) begin
                    m_hold[d] = 1'b0; m_valid[d] = 1'b0;
                end
                m_arm[d] = m_arm[d] | synced;
                m_eo[d]  = !(!m_hold[d] && !ei_l && elig == 4'd0);
            end
        end
        if (!rst_l) begin
            for (int k = 0; k < S; k++) hist[k] = 4'hF;
        end else begin
            for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = i_l;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid%0d", d), 4'(valid_w[d]), 4'(m_valid[d]));
            chk($sformatf("gs%0d", d),    4'(gs_w[d]),    4'(!m_valid[d]));
            chk($sformatf("eo%0d", d),    4'(eo_w[d]),    4'(m_eo[d]));
            if (m_valid[d]) chk($sformatf("code%0d", d), 4'({b_w[d], a_w[d]}), 4'(m_code[d]));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int k = 0; k < S; k++) hist[k] = 4'hF;
        for (int d = 0; d < 2; d++) begin
            m_hold[d] = 1'b0; m_valid[d] = 1'b0; m_code[d] = 2'd0;
            m_eo[d] = 1'b1; m_arm[d] = 4'hF;
        end
        rst_l = 1'b0; ei_l = 1'b0; i_l = 4'hF; ack = 1'b0;
        ticks(2);
        chk("rst_valid", 4'(valid_w[0]), 4'd0);
        chk("rst_gs",    4'(gs_w[0]),    4'd1);
        chk("rst_eo",    4'(eo_w[0]),    4'd1);

        // Idle with no requests.
        rst_l = 1'b1;
        ticks(5);
        chk("idle_valid", 4'(valid_w[0]), 4'd0);
        chk("idle_eo",    4'(eo_w[0]),    4'd0);

        // Line 2 held: code on the 3rd edge, held, no re-report with REARM=1.
        i_l = 4'b1011;
        ticks(3);
        chk("l2_valid", 4'(valid_w[0]), 4'd1);
        chk("l2_code",  4'({b_w[0], a_w[0]}), 4'b0010);
        chk("l2_gs",    4'(gs_w[0]), 4'd0);
        ticks(10);
        chk("l2_hold", 4'({valid_w[0], b_w[0], a_w[0]}), 4'b0110);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("l2_ack", 4'(valid_w[0]), 4'd0);
        ticks(5);
        chk("l2_norearm", 4'(valid_w[0]), 4'd0);
        i_l = 4'hF; ack = 1'b1; ticks(4); ack = 1'b0; ticks(2);

        // Lines 3 and 0 together: 3 first, then 0, then nothing.
        i_l = 4'b0110;
        ticks(3);
        chk("sim_first", 4'({valid_w[0], b_w[0], a_w[0]}), 4'b0111);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("sim_second", 4'({valid_w[0], b_w[0], a_w[0]}), 4'b0100);
        ack = 1'b1; tick(); ack = 1'b0;
        ticks(5);
        chk("sim_none", 4'(valid_w[0]), 4'd0);
        i_l = 4'hF; ack = 1'b1; ticks(4); ack = 1'b0;

        // Disabled by EI_L, then enabled.
        ei_l = 1'b1; i_l = 4'b1110;
        ticks(8);
        chk("ei_valid", 4'(valid_w[0]), 4'd0);
        chk("ei_eo",    4'(eo_w[0]),    4'd1);
        ei_l = 1'b0; tick();
        chk("ei_code", 4'({valid_w[0], b_w[0], a_w[0]}), 4'b0100);
        i_l = 4'hF; ack = 1'b1; ticks(4); ack = 1'b0;

        // Line 1 low/high/low over three handshakes.
        for (int k = 0; k < 3; k++) begin
            i_l = (k == 1) ? 4'hF : 4'b1101;
            ticks(3);
            ack = 1'b1; tick(); ack = 1'b0; tick();
        end
        // Line 1 held: REARM=0 instance reports it on every handshake.
        for (int k = 0; k < 3; k++) begin
            ack = 1'b1; tick(); ack = 1'b0; tick();
            chk("rearm0_code", 4'({valid_w[1], b_w[1], a_w[1]}), 4'b0101);
            chk("rearm1_quiet", 4'(valid_w[0]), 4'd0);
        end
        i_l = 4'hF; ack = 1'b1; ticks(4); ack = 1'b0;

        // Reset during HOLD.
        i_l = 4'b0111;
        ticks(3);
        chk("rh_code", 4'({valid_w[0], b_w[0], a_w[0]}), 4'b0111);
        rst_l = 1'b0; tick(); rst_l = 1'b1;
        chk("rh_valid", 4'(valid_w[0]), 4'd0);
        chk("rh_gs",    4'(gs_w[0]),    4'd1);
        ticks(S);
        chk("rh_wait", 4'(valid_w[0]), 4'd0);
        tick();
        chk("rh_again", 4'({valid_w[0], b_w[0], a_w[0]}), 4'b0111);
        i_l = 4'hF; ack = 1'b1; ticks(4); ack = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) i_l = 4'($urandom);
            ei_l  = ($urandom_range(0, 7) == 0);
            ack   = 1'($urandom_range(0, 1));
            rst_l = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
